// File: rtl/tb_counter.sv
`default_nettype none
// ============================================================================
// Module   : tb_counter
// Brief    : Up/down wrapping counter with an embedded self-checker that raises
//            a sticky err flag when the count breaks its step-by-one property.
// Revision : 1.0 - initial release
// ============================================================================
module tb_counter #(
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mode,
    output logic [WIDTH-1:0] count,
    output logic             err
);

    localparam logic [WIDTH-1:0] c_zero = '0;
    localparam logic [WIDTH-1:0] c_one  = {{(WIDTH-1){1'b0}}, 1'b1};

    // ------------------------------------------------------------------------
    // Counter core
    // ------------------------------------------------------------------------
    logic [WIDTH-1:0] cnt_reg;

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_reg <= c_zero;
        end else if (mode) begin
            cnt_reg <= cnt_reg + c_one;
        end else begin
            cnt_reg <= cnt_reg - c_one;
        end
    end

    assign count = cnt_reg;

    // ------------------------------------------------------------------------
    // Self-checker: sees only cnt_reg and the mode sampled with it, and
    // never feeds back into the core.
    // ------------------------------------------------------------------------
    logic [WIDTH-1:0] past_cnt;
    logic             past_mode;
    logic             past_valid;
    logic [WIDTH-1:0] w_expected;
    logic             w_mismatch;

    assign w_expected = past_mode ? (past_cnt + c_one) : (past_cnt - c_one);

    // Without a valid history the previous edge was a reset, so zero is owed.
    assign w_mismatch = past_valid ? (cnt_reg != w_expected)
                                   : (cnt_reg != c_zero);

    always_ff @(posedge clk) begin
        past_mode <= mode;
        if (!rst) begin
            past_cnt   <= c_zero;
            past_valid <= 1'b0;
            err        <= 1'b0;
        end else begin
            past_cnt   <= cnt_reg;
            past_valid <= 1'b1;
            if (w_mismatch) begin
                err <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_tb_counter.sv
`default_nettype none
// ============================================================================
// Module   : tb_tb_counter
// Brief    : Directed self-checking bench for tb_counter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tb_counter;

    localparam int WIDTH = 10;

    logic             clk;
    logic             rst;
    logic             mode;
    logic [WIDTH-1:0] count;
    logic             err;

    int checks   = 0;
    int failures = 0;

    tb_counter #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .mode  (mode),
        .count (count),
        .err   (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Inputs change just after a falling edge; outputs are read at the next one.
    task automatic step(input logic r, input logic m);
        rst  = r;
        mode = m;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst  = 1'b0;
        mode = 1'b1;
        @(negedge clk);

        // Reset state
        step(1'b0, 1'b1);
        check("reset_count", 32'(count), 32'd0);
        check("reset_err", 32'(err), 32'd0);
        check("reset_past_valid", 32'(dut.past_valid), 32'd0);

        // Count up five cycles
        step(1'b1, 1'b1); check("up_1", 32'(count), 32'd1);
        step(1'b1, 1'b1); check("up_2", 32'(count), 32'd2);
        step(1'b1, 1'b1); check("up_3", 32'(count), 32'd3);
        step(1'b1, 1'b1); check("up_4", 32'(count), 32'd4);
        step(1'b1, 1'b1); check("up_5", 32'(count), 32'd5);
        check("up_err", 32'(err), 32'd0);

        // Down from zero wraps to max
        step(1'b0, 1'b1);
        step(1'b1, 1'b0); check("down_wrap", 32'(count), 32'd1023);
        step(1'b1, 1'b0); check("down_1022", 32'(count), 32'd1022);
        check("down_err", 32'(err), 32'd0);

        // Direction changes with no dead cycle
        step(1'b0, 1'b1);
        step(1'b1, 1'b0); check("dir_1023", 32'(count), 32'd1023);
        for (int i = 0; i < 60; i++) step(1'b1, 1'b1);
        check("dir_59", 32'(count), 32'd59);
        step(1'b1, 1'b0); check("dir_58", 32'(count), 32'd58);
        step(1'b1, 1'b0); check("dir_57", 32'(count), 32'd57);
        check("dir_err", 32'(err), 32'd0);

        // Full up-count wrap at cycle 1024
        step(1'b0, 1'b0);
        step(1'b1, 1'b1); check("wrap_first", 32'(count), 32'd1);
        for (int i = 2; i <= 1023; i++) step(1'b1, 1'b1);
        check("wrap_1023", 32'(count), 32'd1023);
        step(1'b1, 1'b1); check("wrap_0", 32'(count), 32'd0);
        check("wrap_err", 32'(err), 32'd0);

        // Reset mid-count, with mode low, then resume
        step(1'b0, 1'b1);
        for (int i = 0; i < 300; i++) step(1'b1, 1'b1);
        check("mid_300", 32'(count), 32'd300);
        step(1'b0, 1'b0);
        check("mid_reset_count", 32'(count), 32'd0);
        check("mid_reset_past_valid", 32'(dut.past_valid), 32'd0);
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        step(1'b1, 1'b1); check("mid_resume_3", 32'(count), 32'd3);
        check("mid_resume_err", 32'(err), 32'd0);

        // A reset glitch between rising edges has no effect
        #2 rst = 1'b0;
        #2 rst = 1'b1;
        step(1'b1, 1'b1); check("glitch_count", 32'(count), 32'd4);
        check("glitch_err", 32'(err), 32'd0);

        // Corrupt the core and expect a sticky error
        force dut.cnt_reg = 10'd777;
        step(1'b1, 1'b1);
        check("force_err", 32'(err), 32'd1);
        release dut.cnt_reg;
        step(1'b1, 1'b1); check("sticky_count", 32'(count), 32'd778);
        check("sticky_err_1", 32'(err), 32'd1);
        step(1'b1, 1'b1); check("sticky_err_2", 32'(err), 32'd1);
        step(1'b0, 1'b1);
        check("clear_err", 32'(err), 32'd0);
        check("clear_count", 32'(count), 32'd0);
        step(1'b1, 1'b0); check("after_clear_count", 32'(count), 32'd1023);
        check("after_clear_err", 32'(err), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
